// File: rtl/stack_mem_controller_if.sv
// Memory-stage request bus, data-memory port and completion/status signals
// of the stack memory controller.
interface stack_mem_controller_if;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_rdata;
  logic        done;
  logic        err;
  logic [31:0] rsp_data;
  logic        busy;
  logic [31:0] sp;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_rdata,
    input  req_ready, mem_addr, mem_wdata, mem_rd, mem_wr,
           done, err, rsp_data, busy, sp
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
    output req_ready, mem_addr, mem_wdata, mem_rd, mem_wr,
           done, err, rsp_data, busy, sp
  );
endinterface

// File: rtl/stack_mem_controller.sv
// Stack/data memory controller: LOAD/STORE plus 16- and 32-bit PUSH/POP on a
// descending stack over a 16-bit synchronous-read data memory.
module stack_mem_controller #(
  parameter logic [31:0] SP_INIT     = 32'h0000_07FF,
  parameter logic [31:0] STACK_LIMIT = 32'h0000_0400
) (
  input logic                  clk,
  input logic                  rst_n,
  stack_mem_controller_if.slave bus
);
  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_LOAD   = 3'b001;
  localparam logic [2:0] OP_STORE  = 3'b010;
  localparam logic [2:0] OP_PUSH   = 3'b011;
  localparam logic [2:0] OP_POP    = 3'b100;
  localparam logic [2:0] OP_PUSH32 = 3'b101;
  localparam logic [2:0] OP_POP32  = 3'b110;
  localparam logic [2:0] OP_RSVD   = 3'b111;

  typedef enum logic [1:0] {IDLE, W1, W2, RSP} state_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t      state;
  req_t        req;
  logic [31:0] sp_q;
  logic [15:0] lo_q;
  logic        done_q, err_q;
  logic [31:0] rsp_q;

  logic [31:0] sp_p1, sp_p2, sp_m1, sp_m2;
  logic        accept, illegal;
  logic        rd, wr;
  logic [31:0] addr;
  logic [15:0] wdata;

  assign sp_p1 = sp_q + 32'd1;
  assign sp_p2 = sp_q + 32'd2;
  assign sp_m1 = sp_q - 32'd1;
  assign sp_m2 = sp_q - 32'd2;

  assign accept = bus.req_valid && (state == IDLE) && (bus.req_op != OP_NOP);

  // Bounds are judged on the sp seen at accept, so a stack sitting exactly
  // at the limit or exactly empty still admits the op that fits.
  always_comb begin
    illegal = 1'b0;
    case (bus.req_op)
      OP_PUSH:   illegal = sp_q  < STACK_LIMIT;
      OP_POP:    illegal = sp_p1 > SP_INIT;
      OP_PUSH32: illegal = sp_m1 < STACK_LIMIT;
      OP_POP32:  illegal = sp_p2 > SP_INIT;
      OP_RSVD:   illegal = 1'b1;
      default:   illegal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      req    <= '0;
      sp_q   <= SP_INIT;
      lo_q   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      rsp_q  <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (illegal) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              req   <= '{op: bus.req_op, addr: bus.req_addr, wdata: bus.req_wdata};
              state <= W1;
            end
          end
        end
        W1: begin
          case (req.op)
            OP_STORE: begin
              done_q <= 1'b1;
              state  <= IDLE;
            end
            OP_PUSH: begin
              sp_q   <= sp_m1;
              done_q <= 1'b1;
              state  <= IDLE;
            end
            OP_LOAD: state <= RSP;
            OP_POP: begin
              sp_q  <= sp_p1;
              state <= RSP;
            end
            default: state <= W2;
          endcase
        end
        W2: begin
          if (req.op == OP_PUSH32) begin
            sp_q   <= sp_m2;
            done_q <= 1'b1;
            state  <= IDLE;
          end else begin
            // POP32: the low word read in W1 arrives now
            lo_q  <= bus.mem_rdata;
            sp_q  <= sp_p2;
            state <= RSP;
          end
        end
        RSP: begin
          rsp_q  <= (req.op == OP_POP32) ? {bus.mem_rdata, lo_q} : {16'h0000, bus.mem_rdata};
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd    = 1'b0;
    wr    = 1'b0;
    addr  = '0;
    wdata = '0;
    case (state)
      W1: begin
        case (req.op)
          OP_LOAD: begin
            rd   = 1'b1;
            addr = {16'h0000, req.addr};
          end
          OP_STORE: begin
            wr    = 1'b1;
            addr  = {16'h0000, req.addr};
            wdata = req.wdata[15:0];
          end
          OP_PUSH: begin
            wr    = 1'b1;
            addr  = sp_q;
            wdata = req.wdata[15:0];
          end
          OP_PUSH32: begin
            wr    = 1'b1;
            addr  = sp_q;
            wdata = req.wdata[31:16];
          end
          OP_POP, OP_POP32: begin
            rd   = 1'b1;
            addr = sp_p1;
          end
          default: ;
        endcase
      end
      W2: begin
        if (req.op == OP_PUSH32) begin
          wr    = 1'b1;
          addr  = sp_m1;
          wdata = req.wdata[15:0];
        end else begin
          rd   = 1'b1;
          addr = sp_p2;
        end
      end
      default: ;
    endcase
  end

  // Strobes are killed the moment reset is asserted, even mid-operation.
  assign bus.mem_rd    = rd & rst_n;
  assign bus.mem_wr    = wr & rst_n;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;

  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rsp_data  = rsp_q;
  assign bus.sp        = sp_q;
endmodule

// File: tb/tb_stack_mem_controller.sv
// Scoreboard bench: a stack/memory reference model predicts every write, read
// address and completion; negedge monitors compare against the DUT.
module tb_stack_mem_controller;
  localparam logic [31:0] SP_INIT = 32'h0000_07FF;
  localparam logic [31:0] LIMIT   = 32'h0000_0400;
  localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, STORE = 3'd2, PUSH = 3'd3,
                         POP = 3'd4, PUSH32 = 3'd5, POP32 = 3'd6, RSVD = 3'd7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stack_mem_controller_if bif();
  stack_mem_controller #(.SP_INIT(SP_INIT), .STACK_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif)
  );

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rsp;
    logic [31:0] sp;
  } exp_t;
  typedef struct {
    logic [31:0] addr;
    logic [15:0] data;
    logic [15:0] old;
  } wr_t;

  exp_t        exp_q[$];
  wr_t         wr_q[$];
  logic [31:0] rd_q[$];
  logic [15:0] ref_mem  [logic [31:0]];
  logic [15:0] phys_mem [logic [31:0]];
  logic [31:0] msp = SP_INIT;
  logic [31:0] last_rsp = '0;
  int cyc = 0, last_done = 0;
  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Data memory with one-cycle read latency
  always @(posedge clk) begin
    if (bif.mem_wr) phys_mem[bif.mem_addr] = bif.mem_wdata;
    if (bif.mem_rd) bif.mem_rdata <= phys_mem.exists(bif.mem_addr) ? phys_mem[bif.mem_addr] : 16'h0;
  end

  exp_t  me;
  wr_t   mw_e;
  logic [31:0] mra;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bif.mem_rd && bif.mem_wr) chk("strobe_exclusive", 1, 0);
      if (bif.mem_wr) begin
        if (wr_q.size() == 0) chk("unexpected_write", bif.mem_addr, 64'hFFFF_FFFF_FFFF);
        else begin
          mw_e = wr_q.pop_front();
          chk("wr_addr", bif.mem_addr, mw_e.addr);
          chk("wr_data", bif.mem_wdata, mw_e.data);
        end
      end
      if (bif.mem_rd) begin
        if (rd_q.size() == 0) chk("unexpected_read", bif.mem_addr, 64'hFFFF_FFFF_FFFF);
        else begin
          mra = rd_q.pop_front();
          chk("rd_addr", bif.mem_addr, mra);
        end
      end
      if (bif.done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          me = exp_q.pop_front();
          chk("done_cycle", cyc, me.cyc);
          chk("err", bif.err, me.err);
          chk("rsp_data", bif.rsp_data, me.rsp);
          chk("sp", bif.sp, me.sp);
        end
      end else if (bif.err) chk("err_without_done", 1, 0);
    end
  end

  function automatic logic [15:0] rm(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
  endfunction

  task automatic mwrite(input logic [31:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a; w.data = d; w.old = rm(a);
    wr_q.push_back(w);
    ref_mem[a] = d;
  endtask

  // Reference model: evaluated at the accept cycle
  task automatic model(input logic [2:0] op, input logic [15:0] a, input logic [31:0] d);
    exp_t e;
    int lat = 1;
    logic bad = 1'b0;
    if (op == NOP) return;
    e.rsp = last_rsp;
    case (op)
      LOAD: begin
        rd_q.push_back({16'h0, a});
        e.rsp = {16'h0, rm({16'h0, a})};
        lat = 3;
      end
      STORE: begin
        mwrite({16'h0, a}, d[15:0]);
        lat = 2;
      end
      PUSH: begin
        if (msp < LIMIT) bad = 1'b1;
        else begin
          mwrite(msp, d[15:0]);
          msp = msp - 1;
          lat = 2;
        end
      end
      POP: begin
        if (msp + 32'd1 > SP_INIT) bad = 1'b1;
        else begin
          rd_q.push_back(msp + 1);
          e.rsp = {16'h0, rm(msp + 1)};
          msp = msp + 1;
          lat = 3;
        end
      end
      PUSH32: begin
        if (msp - 32'd1 < LIMIT) bad = 1'b1;
        else begin
          mwrite(msp, d[31:16]);
          mwrite(msp - 1, d[15:0]);
          msp = msp - 2;
          lat = 3;
        end
      end
      POP32: begin
        if (msp + 32'd2 > SP_INIT) bad = 1'b1;
        else begin
          rd_q.push_back(msp + 1);
          rd_q.push_back(msp + 2);
          e.rsp = {rm(msp + 2), rm(msp + 1)};
          msp = msp + 2;
          lat = 4;
        end
      end
      default: bad = 1'b1;
    endcase
    if (bad) lat = 1;
    last_rsp = e.rsp;
    e.cyc = cyc + lat;
    e.err = bad;
    e.sp  = msp;
    exp_q.push_back(e);
    last_done = e.cyc;
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [31:0] d);
    int c0, exp_acc;
    int waited = 0;
    @(negedge clk);
    bif.req_valid = 1'b1;
    bif.req_op    = op;
    bif.req_addr  = a;
    bif.req_wdata = d;
    c0 = cyc;
    while (!bif.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bif.req_ready) begin
      chk("accept_timeout", 0, 1);
      bif.req_valid = 1'b0;
      return;
    end
    exp_acc = (last_done > c0) ? last_done : c0;
    chk("accept_cycle", cyc, exp_acc);
    model(op, a, d);
    @(posedge clk);
    #1 bif.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || !bif.req_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  logic [2:0] op_tab [10] = '{NOP, LOAD, STORE, PUSH, PUSH, POP, PUSH32, POP32, POP32, RSVD};

  initial begin
    bif.req_valid = 1'b0; bif.req_op = '0; bif.req_addr = '0; bif.req_wdata = '0;
    bif.mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr", bif.mem_wr, 0);
    chk("rst_rd", bif.mem_rd, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", bif.req_ready, 1);
    chk("rst_busy", bif.busy, 0);
    chk("rst_sp", bif.sp, SP_INIT);
    chk("rst_done", bif.done, 0);
    chk("rst_err", bif.err, 0);
    chk("rst_rsp", bif.rsp_data, 0);

    issue(PUSH, 16'h0, 32'h0000_ABCD);
    wait_idle();
    chk("push_sp", bif.sp, 32'h7FE);
    issue(POP, 16'h0, 32'h0);
    issue(PUSH32, 16'h0, 32'h1234_5678);
    issue(POP32, 16'h0, 32'h0);
    wait_idle();
    chk("pop32_rsp", bif.rsp_data, 32'h1234_5678);
    chk("pop32_sp", bif.sp, SP_INIT);
    issue(POP, 16'h0, 32'h0);
    issue(POP32, 16'h0, 32'h0);
    issue(PUSH, 16'h0, 32'h0000_5A5A);
    issue(POP32, 16'h0, 32'h0);
    issue(POP, 16'h0, 32'h0);

    issue(STORE, 16'h0010, 32'h0000_00AA);
    issue(LOAD, 16'h0010, 32'h0);
    chk("load_busy", bif.busy, 1);
    chk("load_ready", bif.req_ready, 0);
    wait_idle();
    chk("load_rsp", bif.rsp_data, 32'h0000_00AA);
    issue(RSVD, 16'h0, 32'h0);
    wait_idle();
    issue(NOP, 16'h0, 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk("nop_no_done", bif.done, 0);
    end

    // Walk the stack down to the limit and probe both sides of it
    while (msp > 32'h402) issue(PUSH32, 16'h0, $urandom);
    while (msp > 32'h401) issue(PUSH, 16'h0, $urandom);
    issue(PUSH, 16'h0, $urandom);
    issue(PUSH32, 16'h0, $urandom);
    issue(PUSH, 16'h0, $urandom);
    wait_idle();
    chk("limit_sp", bif.sp, 32'h3FF);
    issue(PUSH, 16'h0, $urandom);
    issue(PUSH32, 16'h0, $urandom);
    issue(POP, 16'h0, 32'h0);
    while (msp < 32'h7FE) issue(POP32, 16'h0, 32'h0);
    while (msp < SP_INIT) issue(POP, 16'h0, 32'h0);
    wait_idle();

    // Reset during W2 of a PUSH32
    issue(PUSH32, 16'h0, 32'hCAFE_F00D);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_no_wr", bif.mem_wr, 0);
    chk("midrst_no_rd", bif.mem_rd, 0);
    chk("midrst_pending_wr", wr_q.size(), 1);
    while (wr_q.size() != 0) begin
      wr_t w;
      w = wr_q.pop_back();
      ref_mem[w.addr] = w.old;
    end
    exp_q.delete();
    rd_q.delete();
    msp = SP_INIT; last_rsp = '0; last_done = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", bif.req_ready, 1);
    chk("midrst_sp", bif.sp, SP_INIT);
    chk("midrst_done", bif.done, 0);
    chk("midrst_rsp", bif.rsp_data, 0);

    for (int i = 0; i < 500; i++)
      issue(op_tab[$urandom_range(0, 9)], 16'($urandom_range(0, 31)), $urandom);
    wait_idle();
    chk("end_wr_q", wr_q.size(), 0);
    chk("end_rd_q", rd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stack_mem_controller.md
STACK_MEM_CONTROLLER -- requirements
Module: stack_mem_controller

Interface
REQ-001 SHALL have parameter SP_INIT, default 32'h0000_07FF, meaning the stack pointer reset value and the empty-stack top.
REQ-002 SHALL have parameter STACK_LIMIT, default 32'h0000_0400, meaning the lowest legal stack word address.
REQ-003 SHALL use one clock and a synchronous, active-low reset; the ports are listed below.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 req_valid  in  1  operation request from the memory stage.
REQ-007 req_op  in  3  operation code: 000 NOP, 001 LOAD, 010 STORE, 011 PUSH, 100 POP, 101 PUSH32, 110 POP32, 111 reserved.
REQ-008 req_addr  in  16  LOAD/STORE word address, zero-extended to 32 bits.
REQ-009 req_wdata  in  32  write data: [15:0] for STORE/PUSH; all 32 bits for PUSH32.
REQ-010 req_ready  out  1  request accepted this cycle when high together with req_valid.
REQ-011 mem_addr  out  32  data memory address.
REQ-012 mem_wdata  out  16  data memory write word.
REQ-013 mem_rd / mem_wr  out  1 each  data memory read and write strobes.
REQ-014 mem_rdata  in  16  synchronous read data, valid the cycle after mem_rd.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 err  out  1  qualifies done: the operation was rejected.
REQ-017 rsp_data  out  32  read result, valid with done.
REQ-018 busy  out  1  pipeline stall request.
REQ-019 sp  out  32  current stack pointer.

Function
REQ-020 SHALL implement the FSM states IDLE, W1 (first word), W2 (second word) and RSP (read capture); req_ready = busy_n = (state==IDLE).
REQ-021 In IDLE, req_valid with a non-NOP op SHALL latch op/addr/wdata and go to W1; a NOP SHALL be ignored.
REQ-022 If the accepted op is reserved (111) or illegal (REQ-030), the FSM SHALL stay in IDLE with no memory strobe, and assert done=1, err=1 on the next cycle with sp unchanged.
REQ-023 Memory strobes SHALL be combinational from state and latched op; at most one of mem_rd and mem_wr is high per cycle, and both are low in IDLE and RSP.
REQ-024 LOAD SHALL follow IDLE->W1(rd, req_addr)->RSP->IDLE, with done at accept+3 and rsp_data = {16'h0, word}.
REQ-025 STORE SHALL follow IDLE->W1(wr, req_addr, wdata[15:0])->IDLE, with done at accept+2.
REQ-026 PUSH: W1 SHALL write wdata[15:0] at sp, then sp <= sp-1; done at accept+2.
REQ-027 POP: W1 SHALL read sp+1, then sp <= sp+1, then RSP; done at accept+3 with rsp_data = {16'h0, word}.
REQ-028 PUSH32: W1 SHALL write wdata[31:16] at sp and W2 SHALL write wdata[15:0] at sp-1; sp <= sp-2 after W2; done at accept+3.
REQ-029 POP32: W1 SHALL read sp+1 (low word) and W2 SHALL read sp+2 (high word), capturing the low word; sp <= sp+2 after W2; RSP captures the high word; done at accept+4 with rsp_data = {high, low}.
REQ-030 An op SHALL be illegal if:
  - POP would use sp+1 > SP_INIT;
  - POP32 would use sp+2 > SP_INIT;
  - PUSH has sp < STACK_LIMIT;
  - PUSH32 has sp-1 < STACK_LIMIT.
  Illegal-op checks use the sp value at accept; a stack exactly at the limit or exactly empty is legal for the op that fits.
REQ-031 All sp arithmetic SHALL be 32-bit modulo 2^32; the REQ-030 checks prevent wrap-around in legal operation.
REQ-032 done, err and rsp_data SHALL be registered; done is high exactly one cycle per accepted non-NOP op, and err is 0 whenever done is 0.
REQ-033 rsp_data SHALL hold its value until the next read completion; write completions leave it unchanged.
REQ-034 A req_valid held while busy SHALL NOT be accepted or lost; it is accepted in the first IDLE cycle.
REQ-035 A new request MAY be accepted in the same cycle that done is asserted.

Reset
REQ-036 rst_n=0 at a rising edge SHALL force state=IDLE, sp=SP_INIT, done=0, err=0, rsp_data=0.
REQ-037 mem_rd and mem_wr SHALL be gated low in any cycle where rst_n=0.
REQ-038 A reset mid-operation SHALL drop the operation with no done; sp reverts to SP_INIT even if partially updated.

Verification
REQ-039 Reset, then PUSH 16'hABCD: mem_wr at address 0x7FF, data 0xABCD; sp=0x7FE; done at +2, err=0.
REQ-040 PUSH32 32'h1234_5678 from sp=0x7FF: writes 0x1234@0x7FF then 0x5678@0x7FE; sp=0x7FD. Then POP32 -> rsp_data=0x1234_5678, sp=0x7FF, done at +4.
REQ-041 POP at sp=SP_INIT -> no strobes; done=1, err=1; sp=0x7FF. PUSH at sp=0x3FF -> err. PUSH at sp=0x400 -> accepted.
REQ-042 STORE 0x00AA to addr 0x0010, then LOAD 0x0010 -> rsp_data=0x0000_00AA; req_ready low for 1 cycle (STORE) and 2 cycles (LOAD); back-to-back accept on the done cycle.
REQ-043 Assert rst_n=0 during W2 of a PUSH32 -> no done; no strobe that cycle; sp=0x7FF; req_ready=1 next cycle.
REQ-044 req_op=111 -> done=1, err=1, no memory access; NOP with req_valid=1 -> no done.
